// File: rtl/tt_io_capture_pipe.sv
// Capture pipe between the tile input and output buses: registered pass-through,
// fixed delay line, sample-and-hold and sticky change detector, selected at runtime.
module tt_io_capture_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_strobe,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_dout_valid,
  output logic [CNT_W-1:0] o_change_cnt
);

  localparam int FILL_W = $clog2(DEPTH + 1);

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_DELAY = 2'd1;
  localparam logic [1:0] MODE_HOLD  = 2'd2;
  localparam logic [1:0] MODE_EDGE  = 2'd3;

  logic [WIDTH-1:0]  r_line [DEPTH];
  logic [WIDTH-1:0]  r_prev;
  logic [WIDTH-1:0]  r_sticky;
  logic [WIDTH-1:0]  r_hold;
  logic              r_hold_loaded;
  logic [FILL_W-1:0] r_fill;
  logic [WIDTH-1:0]  r_dout;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;

  logic [WIDTH-1:0]  w_diff;
  logic [WIDTH-1:0]  w_sticky_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_hold_loaded_nxt;
  logic              w_fill_full;
  logic [WIDTH-1:0]  w_dout_nxt;
  logic              w_valid_nxt;

  // A clear in the same cycle as a change still records that change.
  assign w_diff            = i_din ^ r_prev;
  assign w_sticky_nxt      = (i_clear ? '0 : r_sticky) | w_diff;
  assign w_cnt_nxt         = (i_clear ? '0 : r_cnt) + CNT_W'(|w_diff);
  assign w_hold_loaded_nxt = i_strobe | (~i_clear & r_hold_loaded);
  assign w_fill_full       = (r_fill == FILL_W'(DEPTH));

  always_comb begin
    w_dout_nxt  = '0;
    w_valid_nxt = 1'b0;
    case (i_mode)
      MODE_PASS: begin
        w_dout_nxt  = i_din;
        w_valid_nxt = 1'b1;
      end
      MODE_DELAY: begin
        w_dout_nxt  = r_line[DEPTH-1];
        w_valid_nxt = w_fill_full;
      end
      MODE_HOLD: begin
        w_dout_nxt  = i_strobe ? i_din : r_hold;
        w_valid_nxt = w_hold_loaded_nxt;
      end
      MODE_EDGE: begin
        w_dout_nxt  = w_sticky_nxt;
        w_valid_nxt = 1'b1;
      end
      default: begin
        w_dout_nxt  = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
      r_prev        <= '0;
      r_sticky      <= '0;
      r_hold        <= '0;
      r_hold_loaded <= 1'b0;
      r_fill        <= '0;
      r_dout        <= '0;
      r_valid       <= 1'b0;
      r_cnt         <= '0;
    end else if (i_en) begin
      r_line[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
      r_prev <= i_din;
      if (!w_fill_full) r_fill <= r_fill + FILL_W'(1);
      r_sticky      <= w_sticky_nxt;
      r_cnt         <= w_cnt_nxt;
      if (i_strobe) r_hold <= i_din;
      r_hold_loaded <= w_hold_loaded_nxt;
      r_dout        <= w_dout_nxt;
      r_valid       <= w_valid_nxt;
    end else if (i_clear) begin
      // Frozen cycle: only the clearable state moves; dout catches up on the next enabled edge.
      r_sticky      <= '0;
      r_cnt         <= '0;
      r_hold_loaded <= 1'b0;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_valid;
  assign o_change_cnt = r_cnt;

endmodule

// File: tb/tb_tt_io_capture_pipe.sv
// Bench for tt_io_capture_pipe: two instances (DEPTH=4/CNT_W=8 and DEPTH=2/CNT_W=2)
// share stimulus and are compared every cycle against a history-based model.
module tb_tt_io_capture_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       strobe = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout_a, dout_b;
  logic       valid_a, valid_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tt_io_capture_pipe #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_strobe(strobe),
    .i_clear(clear), .i_din(din), .o_dout(dout_a), .o_dout_valid(valid_a),
    .o_change_cnt(cnt_a));

  tt_io_capture_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(2)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_strobe(strobe),
    .i_clear(clear), .i_din(din), .o_dout(dout_b), .o_dout_valid(valid_b),
    .o_change_cnt(cnt_b));

  // Model: history of enabled samples since reset plus the clearable quantities.
  logic [7:0] hist[$];
  logic [7:0] m_sticky = 8'h00;
  int         m_cnt = 0;
  logic [7:0] m_hold = 8'h00;
  logic       m_hl = 1'b0;
  logic [7:0] e_dout [2];
  logic       e_valid [2];

  task automatic model_step();
    logic [7:0] prev;
    int n, d;
    logic hl_new;
    if (rst) begin
      hist.delete();
      m_sticky = 8'h00; m_cnt = 0; m_hold = 8'h00; m_hl = 1'b0;
      for (int k = 0; k < 2; k++) begin e_dout[k] = 8'h00; e_valid[k] = 1'b0; end
    end else if (en) begin
      n = hist.size();
      prev = (n > 0) ? hist[n-1] : 8'h00;
      m_sticky = (clear ? 8'h00 : m_sticky) | (din ^ prev);
      m_cnt = (clear ? 0 : m_cnt) + ((din != prev) ? 1 : 0);
      hl_new = strobe || (!clear && m_hl);
      for (int k = 0; k < 2; k++) begin
        d = (k == 0) ? 4 : 2;
        case (mode)
          2'd0: begin e_dout[k] = din; e_valid[k] = 1'b1; end
          2'd1: begin e_dout[k] = (n >= d) ? hist[n-d] : 8'h00; e_valid[k] = (n >= d); end
          2'd2: begin e_dout[k] = strobe ? din : m_hold; e_valid[k] = hl_new; end
          default: begin e_dout[k] = m_sticky; e_valid[k] = 1'b1; end
        endcase
      end
      if (strobe) m_hold = din;
      m_hl = hl_new;
      hist.push_back(din);
      if (hist.size() > 20) void'(hist.pop_front());
    end else if (clear) begin
      m_sticky = 8'h00; m_cnt = 0; m_hl = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("dout_a",  {24'h0, dout_a},  {24'h0, e_dout[0]});
    chk("valid_a", {31'h0, valid_a}, {31'h0, e_valid[0]});
    chk("cnt_a",   {24'h0, cnt_a},   m_cnt % 256);
    chk("dout_b",  {24'h0, dout_b},  {24'h0, e_dout[1]});
    chk("valid_b", {31'h0, valid_b}, {31'h0, e_valid[1]});
    chk("cnt_b",   {30'h0, cnt_b},   m_cnt % 4);
  endtask

  task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                     input logic s, input logic c, input logic [7:0] d);
    rst = r; en = e; mode = m; strobe = s; clear = c; din = d;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    #1;
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("reset dout", {24'h0, dout_a}, 32'h0);
    chk("reset valid", {31'h0, valid_a}, 32'h0);
    chk("reset cnt", {24'h0, cnt_a}, 32'h0);

    // PASS
    cyc(0, 1, 0, 0, 0, 8'hA5);
    chk("pass A5", {24'h0, dout_a}, 32'hA5);
    cyc(0, 1, 0, 0, 0, 8'h3C);
    chk("pass 3C", {24'h0, dout_a}, 32'h3C);
    chk("pass valid", {31'h0, valid_a}, 32'h1);

    // DELAY from reset
    cyc(1, 0, 1, 0, 0, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 1, 0, 0, 8'(i));
      chk("delay fill valid", {31'h0, valid_a}, 32'h0);
    end
    cyc(0, 1, 1, 0, 0, 8'd5);
    chk("delay first", {24'h0, dout_a}, 32'h1);
    chk("delay valid", {31'h0, valid_a}, 32'h1);
    cyc(0, 1, 1, 0, 0, 8'd6);
    chk("delay second", {24'h0, dout_a}, 32'h2);
    // en=0 freeze with din changing
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0, 8'(8'h90 + i));
      chk("delay frozen", {24'h0, dout_a}, 32'h2);
    end
    cyc(0, 1, 1, 0, 0, 8'd7);
    chk("delay resume", {24'h0, dout_a}, 32'h3);

    // HOLD
    cyc(1, 0, 2, 0, 0, 8'h00);
    cyc(0, 1, 2, 1, 0, 8'h55);
    for (int i = 0; i < 3; i++) cyc(0, 1, 2, 0, 0, 8'(i * 8'h11 + 8'h0F));
    chk("hold keeps", {24'h0, dout_a}, 32'h55);
    cyc(0, 1, 2, 1, 1, 8'h77);
    chk("hold clear+strobe", {24'h0, dout_a}, 32'h77);
    chk("hold valid", {31'h0, valid_a}, 32'h1);

    // EDGE
    cyc(1, 0, 3, 0, 0, 8'h00);
    cyc(0, 1, 3, 0, 0, 8'h00);
    cyc(0, 1, 3, 0, 0, 8'h01);
    cyc(0, 1, 3, 0, 0, 8'h00);
    cyc(0, 1, 3, 0, 0, 8'h80);
    chk("edge sticky", {24'h0, dout_a}, 32'h81);
    chk("edge cnt", {24'h0, cnt_a}, 32'h3);
    cyc(0, 1, 3, 0, 1, 8'h80);
    chk("edge clear dout", {24'h0, dout_a}, 32'h0);
    chk("edge clear cnt", {24'h0, cnt_a}, 32'h0);

    // counter wrap on the narrow instance, then mid-run reset
    cyc(1, 0, 3, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 1, 3, 0, 0, (i % 2 == 0) ? 8'h01 : 8'h00);
    chk("wrap cnt_b", {30'h0, cnt_b}, 32'h1);
    chk("nowrap cnt_a", {24'h0, cnt_a}, 32'h5);
    cyc(1, 1, 3, 0, 0, 8'hFF);
    chk("midrst dout", {24'h0, dout_a}, 32'h0);
    chk("midrst cnt", {24'h0, cnt_a}, 32'h0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 2) == 0) ? din : 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 3));
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0),
          d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
